// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit for the execute stage.
// Runs a shift-add multiply or a restoring divide over WIDTH cycles on
// magnitudes, then applies sign correction and special-case overrides.
//
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous, active-high reset
//   start   - request a new operation (accepted when not busy)
//   kill    - pipeline flush; aborts any operation, no done pulse
//   Funct3  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//             100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_a    - rs1 operand (multiplicand / dividend)
//   op_b    - rs2 operand (multiplier / divisor)
//   busy    - operation in flight (PREP, CALC, FIX)
//   stall   - pipeline hold request, raised combinationally on start
//   done    - one-cycle pulse, result valid
//   result  - final result, held until the next completed operation
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  // hi:lo is the product register for multiply, remainder:quotient for divide
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;
  logic [CW-1:0]    counter;
  logic             neg_res;
  logic             neg_rem;
  logic             div_zero;
  logic             div_ovf;

  logic accept;

  assign busy   = (state == PREP) || (state == CALC) || (state == FIX);
  assign done   = (state == DONE);
  assign stall  = busy | (start & ~busy);
  assign accept = start & ~busy & ~kill;

  // Operand conditioning from the latched opcode
  logic             is_div;
  logic             a_signed;
  logic             b_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    is_div   = f3_q[2];
    // MULHU and the unsigned divides treat op_a as unsigned
    a_signed = is_div ? ~f3_q[0] : (f3_q[1:0] != 2'b11);
    // MULHSU and MULHU treat op_b as unsigned
    b_signed = is_div ? ~f3_q[0] : ~f3_q[1];
    a_neg    = a_signed & a_q[WIDTH-1];
    b_neg    = b_signed & b_q[WIDTH-1];
    a_mag    = a_neg ? (~a_q + 1'b1) : a_q;
    b_mag    = b_neg ? (~b_q + 1'b1) : b_q;
  end

  // One iteration step for each algorithm
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic             rem_ge;

  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    rem_sh   = {hi, lo[WIDTH-1]};
    // when rem_ge holds the true difference is below opnd, so WIDTH bits suffice
    rem_diff = rem_sh[WIDTH-1:0] - opnd;
    rem_ge   = (rem_sh >= {1'b0, opnd});
  end

  // Sign correction and result selection
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_val;

  always_comb begin
    prod     = {hi, lo};
    prod_fix = neg_res ? (~prod + 1'b1) : prod;
    quot_fix = neg_res ? (~lo + 1'b1) : lo;
    rem_fix  = neg_rem ? (~hi + 1'b1) : hi;
    if (div_zero) begin
      quot_fix = '1;
      rem_fix  = a_q;
    end else if (div_ovf) begin
      quot_fix = a_q;
      rem_fix  = '0;
    end
    case (f3_q)
      3'b000:                 fix_val = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_val = quot_fix;
      default:                fix_val = rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      counter  <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      result   <= '0;
    end else if (kill) begin
      state <= IDLE;
    end else begin
      // accept only fires in IDLE or DONE, so latching here covers both
      if (accept) begin
        f3_q <= Funct3;
        a_q  <= op_a;
        b_q  <= op_b;
      end
      case (state)
        IDLE: begin
          if (start) state <= PREP;
        end
        PREP: begin
          hi       <= '0;
          counter  <= '0;
          lo       <= is_div ? a_mag : b_mag;
          opnd     <= is_div ? b_mag : a_mag;
          neg_res  <= a_neg ^ b_neg;
          neg_rem  <= a_neg;
          div_zero <= is_div & (b_q == '0);
          div_ovf  <= is_div & ~f3_q[0] & (b_q == '1)
                      & (a_q == {1'b1, {(WIDTH-1){1'b0}}});
          state    <= CALC;
        end
        CALC: begin
          if (is_div) begin
            hi <= rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], rem_ge};
          end else begin
            hi <= mul_sum[WIDTH:1];
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
          end
          counter <= counter + 1'b1;
          if (counter == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          result <= fix_val;
          state  <= DONE;
        end
        DONE: begin
          state <= start ? PREP : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: an arithmetic reference model with
// a busy-cycle countdown is compared against the DUT on every cycle, and
// directed operations pin the model with hand-computed results.
module tb_muldiv_sequencer;

  localparam int unsigned WIDTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        kill;
  logic [2:0]  Funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_left;
  bit          m_done;
  logic [31:0] m_result;
  logic [31:0] m_pend;

  muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .kill   (kill),
    .Funct3 (Funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] p;
    bit          ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub;
        return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub;
        return p[31:0];
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left   = 0;
    m_done   = 0;
    m_result = '0;
    m_pend   = '0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else if (kill) begin
      m_left = 0;
      m_done = 0;
    end else if (start && m_left == 0) begin
      m_pend = ref_op(Funct3, op_a, op_b);
      m_left = WIDTH + 2;
      m_done = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
      if (m_done) m_result = m_pend;
    end else begin
      m_done = 0;
    end
  endtask

  task automatic compare();
    logic m_busy;
    m_busy = (m_left > 0);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("stall", 32'(stall), 32'(m_busy | (start & ~m_busy)));
    chk("result", result, m_result);
  endtask

  // One cycle: compare away from the edge, advance the model on the edge,
  // then leave inputs free to change just after it.
  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 40 && done !== 1'b1) begin
      step();
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n;
    chk({name, "_model"}, ref_op(f, a, b), exp);
    Funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    #1;
    chk({name, "_stall_on_start"}, 32'(stall), 32'd1);
    step();
    // operands are latched; scramble the inputs
    start  = 1'b0;
    Funct3 = ~f;
    op_a   = ~a;
    op_b   = 32'h5A5A_5A5A;
    wait_done(n);
    chk({name, "_latency"}, 32'(n), 32'(WIDTH + 2));
    chk({name, "_result"}, result, exp);
    step();
  endtask

  initial begin
    int n;
    int dones;
    reset  = 1'b1;
    start  = 1'b0;
    kill   = 1'b0;
    Funct3 = '0;
    op_a   = '0;
    op_b   = '0;
    model_reset();
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_result", result, 32'd0);
    step();
    step();
    reset = 1'b0;
    step();

    run_op("mul",       3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulh",      3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    run_op("mulhu",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu",    3'd2, 32'hFFFF_FFFF,  32'h0000_0002, 32'hFFFF_FFFF);
    run_op("div",       3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    run_op("rem",       3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    run_op("divu",      3'd5, 32'd100,        32'd7,         32'd14);
    run_op("remu",      3'd7, 32'd100,        32'd7,         32'd2);
    run_op("divu_zero", 3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF);
    run_op("remu_zero", 3'd7, 32'd5,          32'd0,         32'd5);
    run_op("div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
    run_op("div_zero",  3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF);
    run_op("rem_zero",  3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9);

    // Back-to-back: start held through DONE launches the next op directly
    Funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    step();
    Funct3 = 3'd7;
    wait_done(n);
    chk("b2b_first_latency", 32'(n), 32'(WIDTH + 2));
    chk("b2b_first_result", result, 32'd14);
    step();
    chk("b2b_no_idle_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(n);
    chk("b2b_second_latency", 32'(n), 32'(WIDTH + 2));
    chk("b2b_second_result", result, 32'd2);
    step();

    // A start pulsed mid-CALC is ignored
    Funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    Funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(n);
    chk("midcalc_latency", 32'(n), 32'(WIDTH + 2 - 13));
    chk("midcalc_result", result, 32'd15);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1) dones++;
    end
    chk("midcalc_single_done", 32'(dones), 32'd0);

    // Kill in CALC cycle 10
    Funct3 = 3'd4; op_a = 32'hFFFF_FFF9; op_b = 32'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 11; i++) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_busy", 32'(busy), 32'd0);
    chk("kill_done", 32'(done), 32'd0);
    chk("kill_result_kept", result, 32'd15);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1) dones++;
    end
    chk("kill_no_done", 32'(dones), 32'd0);

    // Simultaneous kill and start: kill wins
    Funct3 = 3'd0; op_a = 32'd2; op_b = 32'd2; start = 1'b1; kill = 1'b1;
    step();
    start = 1'b0; kill = 1'b0;
    chk("kill_wins_busy", 32'(busy), 32'd0);
    step();

    // Asynchronous reset mid-CALC
    Funct3 = 3'd3; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_done", 32'(done), 32'd0);
    chk("async_reset_result", result, 32'd0);
    model_reset();
    step();
    step();
    reset = 1'b0;
    step();
    run_op("post_reset_remu", 3'd7, 32'd100, 32'd7, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
